// File: rtl/axi_stream_strip_header_if.sv
// Stream-side signals of the header stripper: payload in, strip count, payload out, stripped header.
// slave is the stripper's view; master is the view of whoever drives and consumes it.
interface axi_stream_strip_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_strip;
    logic [BYTE_CNT_WD-1:0]  strip_cnt;
    logic                    ready_strip;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_hdr;
    logic [DATA_WD-1:0]      data_hdr;
    logic [DATA_BYTE_WD-1:0] keep_hdr;
    logic                    ready_hdr;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, valid_strip, strip_cnt, ready_out, ready_hdr,
        output ready_in, ready_strip, valid_out, data_out, keep_out, last_out,
               valid_hdr, data_hdr, keep_hdr
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, valid_strip, strip_cnt, ready_out, ready_hdr,
        input  ready_in, ready_strip, valid_out, data_out, keep_out, last_out,
               valid_hdr, data_hdr, keep_hdr
    );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips strip_cnt+1 leading bytes per packet, re-packs the payload MSB-first, emits removed bytes on the header port.
// 1-cycle latency through registered outputs; input stalls on a busy output register, and a packet start also stalls on a full header register.
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic clk,
    input  logic rst_n,
    axi_stream_strip_header_if.slave bus
);
    localparam int LEN_WD = BYTE_CNT_WD + 2;
    localparam int SH_WD  = LEN_WD + 3;
    localparam logic [LEN_WD-1:0]       NB   = LEN_WD'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] ONES = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BODY  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [LEN_WD-1:0] n);
        return ~(ONES >> n);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [LEN_WD-1:0] n);
        return ~(ONES << n);
    endfunction

    logic [1:0]              state;
    logic                    cnt_held;
    logic [BYTE_CNT_WD-1:0]  cnt_q;
    logic [LEN_WD-1:0]       s_q;
    logic [DATA_WD-1:0]      res_q;
    logic [DATA_BYTE_WD-1:0] flush_keep;
    logic                    out_vld, out_last, hdr_vld;
    logic [DATA_WD-1:0]      out_dat, hdr_dat;
    logic [DATA_BYTE_WD-1:0] out_keep, hdr_keep;

    logic                    out_free, hdr_free, in_rdy, acc;
    logic [DATA_WD-1:0]      data_m, res_next, body_dat, hdr_next;
    logic [LEN_WD-1:0]       vcnt, s_cur, rem, hlen, first_len, body_len;
    logic [SH_WD-1:0]        s_sh, rem_sh, hdr_sh;

    assign out_free = !out_vld || bus.ready_out;
    assign hdr_free = !hdr_vld || bus.ready_hdr;

    always_comb begin
        in_rdy = 1'b0;
        case (state)
            IDLE:    in_rdy = cnt_held && hdr_free && out_free;
            BODY:    in_rdy = out_free;
            default: in_rdy = 1'b0;
        endcase
    end

    assign bus.ready_in    = rst_n && in_rdy;
    assign bus.ready_strip = rst_n && !cnt_held;
    assign acc             = bus.valid_in && bus.ready_in;

    // Bytes outside keep are zeroed so they can never leak into the padding of a short beat.
    always_comb begin
        data_m = '0;
        vcnt   = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            data_m[8*i +: 8] = bus.keep_in[i] ? bus.data_in[8*i +: 8] : 8'h00;
            if (bus.keep_in[i]) vcnt = vcnt + LEN_WD'(1);
        end
    end

    assign s_cur     = (state == IDLE) ? LEN_WD'(cnt_q) + LEN_WD'(1) : s_q;
    assign rem       = NB - s_cur;
    assign hlen      = (vcnt < s_cur) ? vcnt : s_cur;
    assign first_len = (vcnt > s_cur) ? vcnt - s_cur : '0;
    assign body_len  = rem + vcnt;
    assign s_sh      = {s_cur, 3'b000};
    assign rem_sh    = {rem, 3'b000};
    assign hdr_sh    = {NB - hlen, 3'b000};
    assign hdr_next  = data_m >> hdr_sh;
    assign res_next  = data_m << s_sh;
    assign body_dat  = res_q | (data_m >> rem_sh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_held   <= 1'b0;
            cnt_q      <= '0;
            s_q        <= '0;
            res_q      <= '0;
            flush_keep <= '0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            hdr_vld    <= 1'b0;
            hdr_dat    <= '0;
            hdr_keep   <= '0;
        end else begin
            if (bus.ready_out) out_vld <= 1'b0;
            if (bus.ready_hdr) hdr_vld <= 1'b0;
            if (bus.valid_strip && !cnt_held) begin
                cnt_held <= 1'b1;
                cnt_q    <= bus.strip_cnt;
            end
            case (state)
                IDLE: if (acc) begin
                    cnt_held <= 1'b0;
                    s_q      <= s_cur;
                    res_q    <= res_next;
                    hdr_vld  <= 1'b1;
                    hdr_dat  <= hdr_next;
                    hdr_keep <= low_mask(hlen);
                    if (bus.last_in) begin
                        // Short packets still emit one (possibly empty) beat to mark the boundary.
                        out_vld  <= 1'b1;
                        out_dat  <= res_next;
                        out_keep <= top_mask(first_len);
                        out_last <= 1'b1;
                    end else begin
                        state <= BODY;
                    end
                end
                BODY: if (acc) begin
                    res_q   <= res_next;
                    out_vld <= 1'b1;
                    out_dat <= body_dat;
                    if (!bus.last_in) begin
                        out_keep <= ONES;
                        out_last <= 1'b0;
                    end else if (body_len <= NB) begin
                        out_keep <= top_mask(body_len);
                        out_last <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        out_keep   <= ONES;
                        out_last   <= 1'b0;
                        flush_keep <= top_mask(body_len - NB);
                        state      <= FLUSH;
                    end
                end
                FLUSH: if (out_free) begin
                    out_vld  <= 1'b1;
                    out_dat  <= res_q;
                    out_keep <= flush_keep;
                    out_last <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valid_out = out_vld;
    assign bus.data_out  = out_dat;
    assign bus.keep_out  = out_keep;
    assign bus.last_out  = out_last;
    assign bus.valid_hdr = hdr_vld;
    assign bus.data_hdr  = hdr_dat;
    assign bus.keep_hdr  = hdr_keep;
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Bench for axi_stream_strip_header: byte-level packet model (header = leading bytes, payload chunked into beats)
// checked against every output/header handshake, plus directed boundary and reset scenarios.
module tb_axi_stream_strip_header;
    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } out_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; } hdr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_stream_strip_header_if bus ();
    axi_stream_strip_header dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0, errors = 0, cyc = 0, np = 0, rdy_mode = 0;
    bit   mon_en = 1'b0, hold_chk = 1'b0, gaps = 1'b0;
    out_t held, e_o;
    hdr_t e_h;
    out_t exp_out[$];
    hdr_t exp_hdr[$];
    int   in_cyc[$], out_cyc[$];
    int   plen[64], ps[64];
    logic [7:0] pb[64][32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Ready generator: 0 = both ready, 1 = both random, 2 = output random / header blocked.
    initial forever begin
        case (rdy_mode)
            1:       begin bus.ready_out = 1'($urandom_range(0, 1)); bus.ready_hdr = 1'($urandom_range(0, 1)); end
            2:       begin bus.ready_out = 1'($urandom_range(0, 1)); bus.ready_hdr = 1'b0; end
            default: begin bus.ready_out = 1'b1; bus.ready_hdr = 1'b1; end
        endcase
        @(posedge clk);
        #1;
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.valid_out && bus.ready_out) begin
                out_cyc.push_back(cyc);
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected: got %h, expected no beat", {bus.data_out, bus.keep_out, bus.last_out});
                end else begin
                    e_o = exp_out.pop_front();
                    check("out_beat", 64'({bus.data_out, bus.keep_out, bus.last_out}), 64'(e_o));
                end
            end
            if (bus.valid_hdr && bus.ready_hdr) begin
                if (exp_hdr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hdr_unexpected: got %h, expected no header", {bus.data_hdr, bus.keep_hdr});
                end else begin
                    e_h = exp_hdr.pop_front();
                    check("hdr", 64'({bus.data_hdr, bus.keep_hdr}), 64'(e_h));
                end
            end
            if (hold_chk)
                check("out_hold", 64'({bus.valid_out, bus.data_out, bus.keep_out, bus.last_out}), 64'({1'b1, held}));
            hold_chk = bus.valid_out && !bus.ready_out;
            held     = {bus.data_out, bus.keep_out, bus.last_out};
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic mk_pkt(input int len, input int s, input logic [127:0] v, input bit rnd, output int p);
        p = np;
        np++;
        plen[p] = len;
        ps[p]   = s;
        for (int j = 0; j < 32; j++) begin
            if (rnd || j >= 16) pb[p][j] = 8'($urandom);
            else                pb[p][j] = v[127-8*j -: 8];
        end
    endtask

    // Reference: header = first min(S,len) bytes right-aligned; payload = the rest, chunked MSB-first.
    task automatic add_expect(input int p);
        int   h, pay;
        hdr_t eh;
        out_t o;
        h  = (plen[p] < ps[p]) ? plen[p] : ps[p];
        eh = '0;
        for (int j = 0; j < h; j++) eh = {eh.d[23:0], pb[p][j], eh.k[2:0], 1'b1};
        exp_hdr.push_back(eh);
        pay = plen[p] - h;
        if (pay == 0) begin
            o = '0;
            o.l = 1'b1;
            exp_out.push_back(o);
        end
        for (int c = 0; c < pay; c += 4) begin
            o = '0;
            for (int j = 0; j < 4 && c + j < pay; j++) begin
                o.d[31-8*j -: 8] = pb[p][h+c+j];
                o.k[3-j]         = 1'b1;
            end
            o.l = (c + 4 >= pay);
            exp_out.push_back(o);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        bit done = 1'b0;
        bus.data_in = d; bus.keep_in = k; bus.last_in = l; bus.valid_in = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.ready_in) begin
                done = 1'b1;
                in_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic send_beat(input int p, input int i);
        logic [31:0] d;
        logic [3:0]  k;
        int          nb;
        nb = (plen[p] + 3) / 4;
        for (int j = 0; j < 4; j++) begin
            k[3-j]           = (4*i + j < plen[p]);
            d[31-8*j -: 8]   = k[3-j] ? pb[p][4*i+j] : 8'($urandom);
        end
        drive_beat(d, k, i == nb - 1);
    endtask

    task automatic send_beats(input int p, input int from);
        for (int i = from; i < (plen[p] + 3) / 4; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_beat(p, i);
        end
    endtask

    task automatic send_strip(input int p);
        bit done = 1'b0;
        bus.valid_strip = 1'b1;
        bus.strip_cnt   = 2'(ps[p] - 1);
        while (!done) begin
            @(negedge clk);
            done = bus.ready_strip;
            @(posedge clk);
            #1;
        end
        bus.valid_strip = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats and %0d headers outstanding, expected 0", exp_out.size(), exp_hdr.size());
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int p, q, first;
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.valid_strip = 1'b0; bus.strip_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out",   64'(bus.valid_out),   64'd0);
        check("rst_valid_hdr",   64'(bus.valid_hdr),   64'd0);
        check("rst_ready_in",    64'(bus.ready_in),    64'd0);
        check("rst_ready_strip", 64'(bus.ready_strip), 64'd0);
        check("rst_out_regs",    64'({bus.data_out, bus.keep_out, bus.last_out}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready_strip", 64'(bus.ready_strip), 64'd1);
        check("idle_ready_in_nocnt", 64'(bus.ready_in), 64'd0);
        @(posedge clk);
        #1 mon_en = 1'b1;

        mk_pkt(10, 2, {32'hAABBCCDD, 32'h11223344, 16'h5566, 48'h0}, 1'b0, p);
        add_expect(p);
        check("model_p1_hdr", 64'(exp_hdr[0]), 64'({32'h0000AABB, 4'b0011}));
        check("model_p1_b0",  64'(exp_out[0]), 64'({32'hCCDD1122, 4'b1111, 1'b0}));
        check("model_p1_b1",  64'(exp_out[1]), 64'({32'h33445566, 4'b1111, 1'b1}));
        send_strip(p); send_beats(p, 0); wait_drain();

        mk_pkt(10, 1, {32'hAABBCCDD, 32'h11223344, 16'h5566, 48'h0}, 1'b0, p);
        add_expect(p);
        check("model_p2_hdr", 64'(exp_hdr[0]), 64'({32'h000000AA, 4'b0001}));
        check("model_p2_b0",  64'(exp_out[0]), 64'({32'hBBCCDD11, 4'b1111, 1'b0}));
        check("model_p2_b2",  64'(exp_out[2]), 64'({32'h66000000, 4'b1000, 1'b1}));
        send_strip(p); send_beats(p, 0);
        @(negedge clk);
        check("flush_ready_in", 64'(bus.ready_in), 64'd0);
        @(posedge clk); #1;
        wait_drain();

        mk_pkt(4, 4, {32'hAABBCCDD, 96'h0}, 1'b0, p);
        add_expect(p);
        check("model_p3_hdr", 64'(exp_hdr[0]), 64'({32'hAABBCCDD, 4'b1111}));
        check("model_p3_out", 64'(exp_out[0]), 64'({32'h0, 4'b0000, 1'b1}));
        send_strip(p); send_beats(p, 0); wait_drain();

        // Header consumer blocked: the next packet's first beat must stall.
        rdy_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        mk_pkt(9, 3, 128'h0, 1'b1, p);
        mk_pkt(7, 2, 128'h0, 1'b1, q);
        add_expect(p); add_expect(q);
        send_strip(p); send_beats(p, 0); send_strip(q);
        bus.valid_in = 1'b1; bus.data_in = {pb[q][0], pb[q][1], pb[q][2], pb[q][3]};
        bus.keep_in = 4'hF; bus.last_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hdr_stall_ready_in", 64'(bus.ready_in), 64'd0);
            @(posedge clk); #1;
        end
        rdy_mode = 1;
        send_beats(q, 0); wait_drain();

        rdy_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        mk_pkt(32, 2, 128'h0, 1'b1, p);
        add_expect(p);
        in_cyc.delete(); out_cyc.delete();
        send_strip(p); send_beats(p, 0); wait_drain();
        check("tput_in_span",  64'(in_cyc[7] - in_cyc[0]), 64'd7);
        check("tput_out_cnt",  64'(out_cyc.size()), 64'd8);
        check("tput_out_span", 64'(out_cyc[7] - out_cyc[0]), 64'd7);
        check("tput_latency",  64'(out_cyc[0] - in_cyc[1]), 64'd1);

        // Reset in the middle of a packet body discards it.
        mk_pkt(16, 2, 128'h0, 1'b1, p);
        add_expect(p);
        send_strip(p); send_beat(p, 0); send_beat(p, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid_out",   64'(bus.valid_out),   64'd0);
        check("midrst_valid_hdr",   64'(bus.valid_hdr),   64'd0);
        check("midrst_ready_in",    64'(bus.ready_in),    64'd0);
        check("midrst_ready_strip", 64'(bus.ready_strip), 64'd1);
        exp_out.delete(); exp_hdr.delete();
        @(posedge clk); #1;
        mk_pkt(11, 3, 128'h0, 1'b1, p);
        add_expect(p);
        send_strip(p); send_beats(p, 0); wait_drain();

        rdy_mode = 1;
        gaps = 1'b1;
        first = np;
        for (int i = 0; i < 30; i++) begin
            mk_pkt($urandom_range(1, 20), $urandom_range(1, 4), 128'h0, 1'b1, p);
            add_expect(p);
        end
        fork
            begin
                for (int i = first; i < np; i++) begin
                    if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
                    send_strip(i);
                end
            end
            begin
                for (int k = first; k < np; k++) send_beats(k, 0);
            end
        join
        wait_drain();
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
